// File: rtl/z_pingpong_ram.sv
// Double-buffered activation RAM: the producer fills one bank while the consumer drains the other.
// Reads have one-cycle latency with r_valid. An optional post-reset sweep zeroes both banks.
module z_pingpong_ram #(
  parameter int unsigned D_WIDTH  = 4,
  parameter int unsigned A_WIDTH  = 4,
  parameter bit          CLEAR_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               w_en,
  input  logic [A_WIDTH-1:0] w_addr,
  input  logic [D_WIDTH-1:0] data_in,
  input  logic               w_done,
  output logic               w_ready,
  input  logic               r_en,
  input  logic [A_WIDTH-1:0] r_addr,
  input  logic               r_done,
  output logic               rd_ready,
  output logic [D_WIDTH-1:0] data_out,
  output logic               r_valid,
  output logic               busy
);

  localparam int unsigned DEPTH = 1 << A_WIDTH;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_wsel;
  logic                 r_rsel;
  logic [1:0]           r_full;
  logic [A_WIDTH-1:0]   r_clr_addr;
  logic [D_WIDTH-1:0]   r_mem0 [DEPTH];
  logic [D_WIDTH-1:0]   r_mem1 [DEPTH];

  logic                 w_wr_go;
  logic                 w_rd_go;
  logic                 w_wdone_go;
  logic                 w_rdone_go;
  logic [D_WIDTH-1:0]   w_rd_dat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CLEAR_EN ? S_CLEAR : S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    w_ready     = 1'b0;
    rd_ready    = 1'b0;
    case (r_state)
      S_CLEAR: begin
        busy = 1'b1;
        if (&r_clr_addr) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_ready  = !r_full[r_wsel];
        rd_ready = r_full[r_rsel];
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  assign w_wr_go    = w_en   & w_ready;
  assign w_wdone_go = w_done & w_ready;
  assign w_rd_go    = r_en   & rd_ready;
  assign w_rdone_go = r_done & rd_ready;
  assign w_rd_dat   = r_rsel ? r_mem1[r_addr] : r_mem0[r_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wsel     <= 1'b0;
      r_rsel     <= 1'b0;
      r_full     <= 2'b00;
      r_clr_addr <= '0;
      data_out   <= '0;
      r_valid    <= 1'b0;
    end else begin
      if (r_state == S_CLEAR) begin
        r_clr_addr <= r_clr_addr + 1'b1;
      end
      r_valid <= w_rd_go;
      if (w_rd_go) begin
        data_out <= w_rd_dat;
      end
      // wsel and rsel always differ when both dones are honoured, so these touch distinct bits
      if (w_wdone_go) begin
        r_full[r_wsel] <= 1'b1;
        r_wsel         <= ~r_wsel;
      end
      if (w_rdone_go) begin
        r_full[r_rsel] <= 1'b0;
        r_rsel         <= ~r_rsel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem0[r_clr_addr] <= '0;
      r_mem1[r_clr_addr] <= '0;
    end else if (w_wr_go) begin
      if (r_wsel) begin
        r_mem1[w_addr] <= data_in;
      end else begin
        r_mem0[w_addr] <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_z_pingpong_ram.sv
// Bench for z_pingpong_ram: directed scenarios plus random traffic against a bank/flag reference model.
module tb_z_pingpong_ram;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       w_en = 1'b0;
  logic [3:0] w_addr = '0;
  logic [3:0] data_in = '0;
  logic       w_done = 1'b0;
  logic       w_ready;
  logic       r_en = 1'b0;
  logic [3:0] r_addr = '0;
  logic       r_done = 1'b0;
  logic       rd_ready;
  logic [3:0] data_out;
  logic       r_valid;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_bank [2][16];
  bit m_full [2];
  int m_wsel, m_rsel, m_clear_left, m_dout;
  bit m_rvalid;

  z_pingpong_ram #(.D_WIDTH(4), .A_WIDTH(4), .CLEAR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .w_en(w_en), .w_addr(w_addr), .data_in(data_in), .w_done(w_done), .w_ready(w_ready),
    .r_en(r_en), .r_addr(r_addr), .r_done(r_done), .rd_ready(rd_ready),
    .data_out(data_out), .r_valid(r_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < 16; a++) m_bank[b][a] = 0;
      m_full[b] = 0;
    end
    m_wsel = 0; m_rsel = 0; m_clear_left = 16; m_dout = 0; m_rvalid = 0;
  endtask

  task automatic model_update();
    bit wr, rr;
    if (m_clear_left > 0) begin
      m_clear_left--;
      m_rvalid = 0;
    end else begin
      wr = !m_full[m_wsel];
      rr = m_full[m_rsel];
      m_rvalid = r_en && rr;
      if (m_rvalid) m_dout = m_bank[m_rsel][r_addr];
      if (w_en && wr) m_bank[m_wsel][w_addr] = data_in;
      if (w_done && wr) begin m_full[m_wsel] = 1; m_wsel ^= 1; end
      if (r_done && rr) begin m_full[m_rsel] = 0; m_rsel ^= 1; end
    end
  endtask

  task automatic check_outputs();
    bit b;
    b = (m_clear_left > 0);
    chk("busy", busy, b);
    chk("w_ready", w_ready, !b && !m_full[m_wsel]);
    chk("rd_ready", rd_ready, !b && m_full[m_rsel]);
    chk("r_valid", r_valid, m_rvalid);
    chk("data_out", data_out, m_dout);
  endtask

  task automatic step(input bit we, input int wa, input int di, input bit wd,
                      input bit re, input int ra, input bit rd);
    w_en = we; w_addr = wa[3:0]; data_in = di[3:0]; w_done = wd;
    r_en = re; r_addr = ra[3:0]; r_done = rd;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #1;
    chk("rst_busy", busy, 1);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_w_ready", w_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    idle(16);
    chk("sweep_done_busy", busy, 0);
    chk("sweep_done_w_ready", w_ready, 1);
    chk("sweep_done_rd_ready", rd_ready, 0);

    // bank 0 = addr, then read 5 and read 3 together with r_done
    for (int a = 0; a < 16; a++) step(1, a, a, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("rd_ready_after_wdone", rd_ready, 1);
    step(0, 0, 0, 0, 1, 5, 0);
    chk("read5", data_out, 5);
    chk("read5_valid", r_valid, 1);
    step(0, 0, 0, 0, 1, 3, 1);
    chk("read3_with_rdone", data_out, 3);
    chk("rd_ready_after_rdone", rd_ready, 0);

    // both banks full with 15-addr; stray write ignored
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 16; a++) step(1, a, 15 - a, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0);
    end
    chk("both_full_w_ready", w_ready, 0);
    step(1, 0, 9, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("read0_after_full", data_out, 15);

    // one bank full, the other being written: simultaneous dones
    for (int a = 0; a < 4; a++) step(1, a, a + 2, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 1);
    chk("simul_done_rd_ready", rd_ready, 1);
    chk("simul_done_w_ready", w_ready, 1);
    step(0, 0, 0, 0, 1, 2, 0);
    chk("simul_done_read", data_out, 4);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15) == 0, $urandom_range(0, 1), $urandom_range(0, 15),
           $urandom_range(0, 15) == 0);
    end

    // reset during the 8th write of bank 1
    sync_reset();
    idle(16);
    for (int a = 0; a < 16; a++) step(1, a, a + 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    for (int a = 0; a < 6; a++) step(1, a, 7, 0, 0, 0, 0);
    step(1, 6, 7, 0, 1, 9, 0);
    chk("pre_rst_valid", r_valid, 1);
    chk("pre_rst_data", data_out, 10);
    w_en = 1; w_addr = 4'd7; data_in = 4'd7; r_en = 0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_r_valid", r_valid, 0);
    chk("async_rst_data_out", data_out, 0);
    chk("async_rst_busy", busy, 1);
    chk("async_rst_rd_ready", rd_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    idle(15);
    chk("sweep2_still_busy", busy, 1);
    idle(1);
    chk("sweep2_done", busy, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    for (int a = 0; a < 16; a++) begin
      step(0, 0, 0, 0, 1, a, 0);
      chk("cleared_read", data_out, 0);
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/z_pingpong_ram.md
# z_pingpong_ram

Parametrised double-buffered (ping-pong) activation RAM for the DNN layer pipeline. A producer fills one bank while the consumer reads the other, and bank ownership swaps by a done handshake. Read latency is one cycle, with an explicit valid. An optional post-reset clear sweep zeroes both banks, so no initialisation file is needed.

## Interface
- D_WIDTH, 4, data word width in bits.
- A_WIDTH, 4, address width; each bank holds 2**A_WIDTH words.
- CLEAR_EN, 1, when 1 both banks are zeroed after reset; when 0 the sweep is skipped and memory contents are undefined.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- w_en  in  1  write strobe; honoured only when w_ready=1.
- w_addr  in  A_WIDTH  write address within the current write bank.
- data_in  in  D_WIDTH  write data.
- w_done  in  1  producer pulse: current write bank complete; honoured only when w_ready=1.
- w_ready  out  1  write bank is free and no clear sweep is running.
- r_en  in  1  read strobe; honoured only when rd_ready=1.
- r_addr  in  A_WIDTH  read address within the current read bank.
- r_done  in  1  consumer pulse: current read bank consumed; honoured only when rd_ready=1.
- rd_ready  out  1  read bank holds complete data.
- data_out  out  D_WIDTH  read data.
- r_valid  out  1  data_out carries the result of the previous cycle's honoured r_en.
- busy  out  1  clear sweep in progress.

## Operation
- State: wsel, rsel (bank selects, 1 bit each), full[1:0], sweep counter clr_addr (A_WIDTH bits), FSM {CLEAR, RUN}.
- Reset (asynchronous) sets wsel=rsel=0, full=00, clr_addr=0, data_out=0, r_valid=0, and FSM=CLEAR if CLEAR_EN, else RUN. Memory arrays are not reset asynchronously.
- CLEAR: each cycle, writes 0 to clr_addr in both banks and increments clr_addr. After address 2**A_WIDTH-1 is written, goes to RUN. busy=1 throughout. w_ready=rd_ready=0.
- RUN: busy=0. w_ready = !full[wsel]. rd_ready = full[rsel].
- Write: w_en & w_ready writes data_in to bank wsel at w_addr. Ignored otherwise.
- w_done & w_ready sets full[wsel] and toggles wsel.
- Read: r_en & rd_ready reads bank rsel at r_addr. The bank and address are sampled in that cycle.
- r_done & rd_ready clears full[rsel] and toggles rsel.
- An r_en in the same cycle as r_done reads the pre-toggle bank.
- Simultaneous honoured w_done and r_done both take effect.
- wsel==rsel makes w_done and r_done mutually exclusive, because they require opposite full states.
- Writes never target the read bank, so there is no read/write collision.
- data_out holds its last value when no read is honoured.

## Timing
- Clear sweep takes exactly 2**A_WIDTH cycles after rst deasserts; the first honoured write is possible in cycle 2**A_WIDTH.
- Read latency is 1 cycle: r_valid and data_out update on the edge after an honoured r_en. r_valid is a registered copy of (r_en & rd_ready).
- w_ready and rd_ready are combinational from registered state. They update the cycle after the done pulse.
- Back-to-back done pulses on the same side: the second is honoured only if the ready signal is still 1 after the toggle.
- Both banks full: w_ready=0 until r_done. Both empty: rd_ready=0 until w_done.
- Reset asserted mid-operation aborts everything immediately. Outputs return to their reset values asynchronously, and the clear sweep restarts.

## Test plan
- Reset then idle, D_WIDTH=4, A_WIDTH=4, CLEAR_EN=1 -> busy=1 for 16 cycles then 0, w_ready=1, rd_ready=0; after filling, reading any address never written returns 0.
- Write data_in=addr for addr 0..15, pulse w_done -> rd_ready=1 next cycle, wsel=1. Read addr 5 -> data_out=5, r_valid=1 one cycle later.
- Fill bank 0 and bank 1 (data=15-addr) without r_done -> w_ready=0; w_en with data 9 at addr 0 is ignored; after r_done, read addr 0 returns 15.
- Same-cycle r_en(addr 3) and r_done with bank 0 data=addr -> data_out=3; afterwards rsel=1.
- Both banks pending (one full, one being written): w_done and r_done in the same cycle -> full flags, wsel and rsel all update consistently; rd_ready stays 1.
- Assert rst during the 8th write of bank 1 -> r_valid=0, data_out=0, busy=1 immediately; the 16-cycle sweep repeats; all prior data reads back as 0.
